// File: rtl/complex_mult_pipe_if.sv
// complex_mult_pipe_if
//  Handshake bundle for the pipelined complex multiplier.
//  Input side : in_valid/in_ready, operands a,b,c,d (sign-magnitude, N bits), conj.
//  Output side: out_valid/out_ready, results re,im (sign-magnitude, N bits), ovr.
//  master = producer of operands / consumer of results, slave = the multiplier.
interface complex_mult_pipe_if #(
  parameter int N = 24
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] c;
  logic [N-1:0] d;
  logic         conj;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] re;
  logic [N-1:0] im;
  logic         ovr;

  modport master (
    output in_valid, a, b, c, d, conj, out_ready,
    input  in_ready, out_valid, re, im, ovr
  );

  modport slave (
    input  in_valid, a, b, c, d, conj, out_ready,
    output in_ready, out_valid, re, im, ovr
  );
endinterface

// File: rtl/complex_mult_pipe.sv
// complex_mult_pipe
//  Three-stage pipelined complex multiplier on sign-magnitude Q-format words:
//  (a+ib)(c+id), or (a+ib)(c-id) when conj=1. Saturating, with a per-sample
//  overflow flag and a sticky overflow flag.
//  Ports:
//    clk        rising-edge clock
//    rst        synchronous active-high reset, flushes every stage
//    clr        synchronous clear of ovr_sticky (a same-cycle new overflow wins)
//    ovr_sticky OR of every ovr presented since reset or clr
//    bus        complex_mult_pipe_if.slave: operand and result handshakes
//  Stages: S1 operand capture, S2 four products, S3 sums/saturation (output regs).
module complex_mult_pipe #(
  parameter int N = 24,
  parameter int Q = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  output logic                ovr_sticky,
  complex_mult_pipe_if.slave  bus
);
  localparam int MW = N - 1;

  logic         v1, v2, v3;
  logic         en1, en2, en3;
  logic [N-1:0] a1, b1, c1, d1;
  logic [N-1:0] ac2, bd2, ad2, bc2;
  logic         ovr2;
  logic [N-1:0] ac_n, bd_n, ad_n, bc_n;
  logic         of_ac, of_bd, of_ad, of_bc;
  logic [N-1:0] re_n, im_n;
  logic         of_re, of_im;
  logic         ovr_n;
  logic         s3_load;

  // Sign-magnitude Q multiply: truncate toward zero, saturate the magnitude.
  function automatic logic [N-1:0] smul(input logic [N-1:0] x, input logic [N-1:0] y,
                                        output logic of);
    logic [2*MW-1:0] p;
    logic [2*MW-1:0] s;
    logic [MW-1:0]   m;
    p  = {{MW{1'b0}}, x[MW-1:0]} * {{MW{1'b0}}, y[MW-1:0]};
    s  = p >> Q;
    of = |s[2*MW-1:MW];
    m  = of ? '1 : s[MW-1:0];
    return {(x[N-1] ^ y[N-1]) & (|m), m};
  endfunction

  // Sign-magnitude add; a zero magnitude always carries a positive sign.
  function automatic logic [N-1:0] sadd(input logic [N-1:0] x, input logic [N-1:0] y,
                                        output logic of);
    logic [MW:0]   sum;
    logic [MW-1:0] m;
    logic          s;
    sum = '0;
    of  = 1'b0;
    if (x[N-1] == y[N-1]) begin
      sum = {1'b0, x[MW-1:0]} + {1'b0, y[MW-1:0]};
      of  = sum[MW];
      m   = of ? '1 : sum[MW-1:0];
      s   = x[N-1];
    end else if (x[MW-1:0] >= y[MW-1:0]) begin
      m = x[MW-1:0] - y[MW-1:0];
      s = x[N-1];
    end else begin
      m = y[MW-1:0] - x[MW-1:0];
      s = y[N-1];
    end
    return {s & (|m), m};
  endfunction

  // Stall chain: a stage loads when empty or when its successor moves on.
  assign en3          = ~v3 | bus.out_ready;
  assign en2          = ~v2 | en3;
  assign en1          = ~v1 | en2;
  assign bus.in_ready = en1;
  assign bus.out_valid = v3;
  assign s3_load      = en3 & v2;

  always_comb begin
    ac_n = smul(a1, c1, of_ac);
    bd_n = smul(b1, d1, of_bd);
    ad_n = smul(a1, d1, of_ad);
    bc_n = smul(b1, c1, of_bc);
  end

  always_comb begin
    re_n  = sadd(ac2, {~bd2[N-1], bd2[MW-1:0]}, of_re);
    im_n  = sadd(ad2, bc2, of_im);
    ovr_n = ovr2 | of_re | of_im;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      bus.re     <= '0;
      bus.im     <= '0;
      bus.ovr    <= 1'b0;
      ovr_sticky <= 1'b0;
    end else begin
      if (en1) v1 <= bus.in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
      if (s3_load) begin
        bus.re  <= re_n;
        bus.im  <= im_n;
        bus.ovr <= ovr_n;
      end
      if (s3_load && ovr_n) ovr_sticky <= 1'b1;
      else if (clr)         ovr_sticky <= 1'b0;
    end
  end

  // Datapath registers need no reset: their contents only matter behind a valid.
  always_ff @(posedge clk) begin
    if (en1 && bus.in_valid) begin
      a1 <= bus.a;
      b1 <= bus.b;
      c1 <= bus.c;
      d1 <= {bus.d[N-1] ^ bus.conj, bus.d[MW-1:0]};
    end
    if (en2 && v1) begin
      ac2  <= ac_n;
      bd2  <= bd_n;
      ad2  <= ad_n;
      bc2  <= bc_n;
      ovr2 <= of_ac | of_bd | of_ad | of_bc;
    end
  end
endmodule

// File: tb/tb_complex_mult_pipe.sv
module tb_complex_mult_pipe;
  localparam int     N    = 16;
  localparam int     Q    = 8;
  localparam longint MAXM = (64'sd1 <<< (N - 1)) - 1;

  typedef struct {
    logic [N-1:0] re;
    logic [N-1:0] im;
    logic         ovr;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic ovr_sticky;

  always #5 clk = ~clk;

  complex_mult_pipe_if #(.N(N)) bus ();

  complex_mult_pipe #(.N(N), .Q(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .ovr_sticky(ovr_sticky),
    .bus       (bus)
  );

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   accepted = 0;
  int   out_seen = 0;
  bit   lat_chk  = 0;
  bit   rnd_done = 0;
  bit   t4_done  = 0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model in plain signed integers.
  function automatic longint to_int(input logic [N-1:0] x);
    longint m;
    m = longint'(x[N-2:0]);
    return x[N-1] ? -m : m;
  endfunction

  function automatic longint mulq(input longint x, input longint y, inout bit of);
    longint m;
    m = ((x < 0 ? -x : x) * (y < 0 ? -y : y)) >>> Q;
    if (m > MAXM) begin
      of = 1'b1;
      m  = MAXM;
    end
    return ((x < 0) != (y < 0)) ? -m : m;
  endfunction

  function automatic longint sat(input longint v, inout bit of);
    if (v > MAXM) begin
      of = 1'b1;
      return MAXM;
    end
    if (v < -MAXM) begin
      of = 1'b1;
      return -MAXM;
    end
    return v;
  endfunction

  function automatic logic [N-1:0] to_sm(input longint v);
    longint m;
    m = (v < 0) ? -v : v;
    return {(v < 0) ? 1'b1 : 1'b0, m[N-2:0]};
  endfunction

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [N-1:0] c, input logic [N-1:0] d,
                                 input logic cj);
    exp_t   e;
    bit     of;
    longint ar, ai, cr, ci, ac, bd, ad, bc;
    of = 1'b0;
    ar = to_int(a);
    ai = to_int(b);
    cr = to_int(c);
    ci = to_int(d);
    if (cj) ci = -ci;
    ac = mulq(ar, cr, of);
    bd = mulq(ai, ci, of);
    ad = mulq(ar, ci, of);
    bc = mulq(ai, cr, of);
    e.re  = to_sm(sat(ac - bd, of));
    e.im  = to_sm(sat(ad + bc, of));
    e.ovr = of;
    e.cyc = 0;
    return e;
  endfunction

  function automatic logic [N-1:0] rnd_op();
    logic [N-1:0] r;
    r = N'($urandom);
    if ($urandom_range(0, 3) != 0) r[N-2:0] = (N-1)'($urandom_range(0, 1024));
    return r;
  endfunction

  // Output monitor / scoreboard pop.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      out_seen++;
      if (q.size() == 0) begin
        check("unexpected_out", 64'(1), 64'(0));
      end else begin
        e = q.pop_front();
        check("re", 64'(bus.re), 64'(e.re));
        check("im", 64'(bus.im), 64'(e.im));
        check("ovr", 64'(bus.ovr), 64'(e.ovr));
        if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'(3));
      end
    end
  end

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [N-1:0] c, input logic [N-1:0] d, input logic cj);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.c = c;
    bus.d = d;
    bus.conj = cj;
    e = model(a, b, c, d, cj);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("in_ready_timeout", 64'(0), 64'(1));
    end else begin
      e.cyc = cyc;
      q.push_back(e);
      accepted++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 64'(q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int seen0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c         = '0;
    bus.d         = '0;
    bus.conj      = 1'b0;
    bus.out_ready = 1'b1;
    clr           = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_re", 64'(bus.re), 64'(0));
    check("rst_im", 64'(bus.im), 64'(0));
    check("rst_ovr", 64'(bus.ovr), 64'(0));
    check("rst_sticky", 64'(ovr_sticky), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Basic products with latency check.
    lat_chk = 1'b1;
    send(16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0);
    wait_drain();
    send(16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b1);
    wait_drain();
    lat_chk = 1'b0;
    check("known_re_t1", 64'(model(16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0).re), 64'(16'h8500));

    // Negative-zero operand.
    send(16'h8000, 16'h0000, 16'h0100, 16'h0000, 1'b0);
    wait_drain();

    // Saturation, sticky set and clear.
    send(16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 1'b0);
    wait_drain();
    check("sticky_set", 64'(ovr_sticky), 64'(1));
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("sticky_clr", 64'(ovr_sticky), 64'(0));

    // Random stream with random backpressure and input bubbles.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(rnd_op(), rnd_op(), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();

    // Backpressure: six samples against a stalled consumer.
    bus.out_ready = 1'b0;
    accepted = 0;
    t4_done  = 1'b0;
    seen0    = out_seen;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(16'(16'h0100 + 16'(i) * 16'h0040), 16'h8080, 16'h0180, 16'(16'h0020 * 16'(i)), 1'(i % 2));
        t4_done = 1'b1;
      end
    join_none
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bp_accepted", 64'(accepted), 64'(3));
    check("bp_in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 100 && !t4_done; k++) @(posedge clk);
    check("bp_sender_done", 64'(t4_done), 64'(1));
    wait_drain();
    check("bp_out_count", 64'(out_seen - seen0), 64'(6));
    @(negedge clk);
    check("bp_in_ready_back", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Reset with samples in flight.
    send(16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 1'b0);
    wait_drain();
    check("pre_rst_sticky", 64'(ovr_sticky), 64'(1));
    send(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0);
    send(16'h0200, 16'h0000, 16'h0200, 16'h0000, 1'b0);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(bus.out_valid), 64'(0));
    check("flush_sticky", 64'(ovr_sticky), 64'(0));
    check("flush_in_ready", 64'(bus.in_ready), 64'(1));
    seen0 = out_seen;
    repeat (10) @(negedge clk);
    check("flush_no_stale", 64'(out_seen - seen0), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
